// File: rtl/arrow_lane_sequencer.sv
// arrow_lane_sequencer
// Per-player scrolling note lane. A 26-slot queue of 3-bit arrow codes
// scrolls one slot per step (slot 0 = top of screen). New arrows enter at
// slot 0 from a one-deep pending register, and button presses are judged
// against the target block around TARGET_SLOT.
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_PAUSE | enable=0: step counter, lane, indicator timer frozen; presses
//           | ignored; spawns may still be latched into pending
//   S_RUN   | enable=1: scrolling, spawning and judging active
//
// Ports:
//   clock        single clock
//   reset        synchronous, active-high
//   enable       1 = run, 0 = pause
//   spawn_valid  chart source offers spawn_code
//   spawn_code   arrow code (001 up, 010 left, 011 down, 100 right, 110 shake)
//   spawn_ready  pending register empty
//   press_valid  one-cycle debounced press pulse
//   press_code   pressed lane, same encoding as spawn_code
//   step         one-cycle pulse on each scroll step
//   arrow_array  slot i at bits [3i+2:3i]
//   indicator    11 excellent, 10 good, 01 bad, 00 none
//   score        saturating score
//   miss_count   saturating miss count
module arrow_lane_sequencer #(
    parameter int TICK_DIV    = 1666666,
    parameter int HOLD_STEPS  = 8,
    parameter int TARGET_SLOT = 23
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        spawn_valid,
    input  logic [2:0]  spawn_code,
    output logic        spawn_ready,
    input  logic        press_valid,
    input  logic [2:0]  press_code,
    output logic        step,
    output logic [77:0] arrow_array,
    output logic [1:0]  indicator,
    output logic [15:0] score,
    output logic [7:0]  miss_count
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int TW = $clog2(HOLD_STEPS + 1);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(TICK_DIV - 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_STEPS);

    typedef enum logic {
        S_PAUSE = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   run;
    logic   step_now;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [77:0]   lane_q, lane_d;
    logic          pend_v_q, pend_v_d;
    logic [2:0]    pend_code_q, pend_code_d;
    logic [1:0]    ind_q, ind_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [15:0]   score_q, score_d;
    logic [7:0]    miss_q, miss_d;

    logic       hit;
    logic [4:0] hit_idx;
    logic [4:0] clr_idx;
    logic [1:0] judge;
    logic       press_act;
    logic       miss;
    logic [2:0] head;
    logic [16:0] score_sum;

    function automatic logic [2:0] legal_code(input logic [2:0] c);
        case (c)
            3'b001, 3'b010, 3'b011, 3'b100, 3'b110: return c;
            default:                                return 3'b000;
        endcase
    endfunction

    // Mode register. run is taken from the next state so that the lane
    // reacts to enable in the same cycle it changes.
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_PAUSE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        run      = 1'b0;
        step_now = 1'b0;
        case (state_q)
            S_PAUSE: if (enable)  state_d = S_RUN;
            S_RUN:   if (!enable) state_d = S_PAUSE;
        endcase
        run      = (state_d == S_RUN);
        // Down-counter: terminal count 0 corresponds to phase TICK_DIV-1.
        step_now = run && (cnt_q == '0) && !reset;
    end

    assign step = step_now;

    // Judgement window search in priority T, T-1, T+1 on pre-shift contents.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 5'(TARGET_SLOT);
        judge   = 2'b01;
        if (press_code != 3'b000) begin
            if (lane_q[3*TARGET_SLOT +: 3] == press_code) begin
                hit     = 1'b1;
                hit_idx = 5'(TARGET_SLOT);
                judge   = 2'b11;
            end else if (lane_q[3*(TARGET_SLOT-1) +: 3] == press_code) begin
                hit     = 1'b1;
                hit_idx = 5'(TARGET_SLOT - 1);
                judge   = 2'b10;
            end else if (lane_q[3*(TARGET_SLOT+1) +: 3] == press_code) begin
                hit     = 1'b1;
                hit_idx = 5'(TARGET_SLOT + 1);
                judge   = 2'b10;
            end
        end
    end

    always_comb begin
        press_act = run && press_valid;
        miss      = step_now && (lane_q[77:75] != 3'b000);
        head      = pend_v_q ? pend_code_q : 3'b000;

        cnt_d = cnt_q;
        if (run) cnt_d = (cnt_q == '0) ? CNT_LOAD : cnt_q - 1'b1;

        lane_d = lane_q;
        if (step_now) lane_d = {lane_q[74:0], head};
        // A matched arrow is cleared where it sits after any shift this cycle.
        clr_idx = hit_idx + {4'b0000, step_now};
        if (press_act && hit) lane_d[3*clr_idx +: 3] = 3'b000;

        pend_v_d    = pend_v_q;
        pend_code_d = pend_code_q;
        if (spawn_valid && !pend_v_q) begin
            pend_v_d    = 1'b1;
            pend_code_d = legal_code(spawn_code);
        end else if (step_now) begin
            pend_v_d = 1'b0;
        end

        // Press result takes precedence over a simultaneous miss.
        ind_d = ind_q;
        tmr_d = tmr_q;
        if (press_act) begin
            ind_d = judge;
            tmr_d = HOLD_LOAD;
        end else if (miss) begin
            ind_d = 2'b01;
            tmr_d = HOLD_LOAD;
        end else if (step_now && (tmr_q != '0)) begin
            tmr_d = tmr_q - 1'b1;
            if (tmr_q == TW'(1)) ind_d = 2'b00;
        end

        score_sum = {1'b0, score_q};
        if (press_act && hit)
            score_sum = {1'b0, score_q} + ((judge == 2'b11) ? 17'd2 : 17'd1);
        score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];

        miss_d = miss_q;
        if (miss && (miss_q != 8'hFF)) miss_d = miss_q + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= CNT_LOAD;
            lane_q      <= '0;
            pend_v_q    <= 1'b0;
            pend_code_q <= 3'b000;
            ind_q       <= 2'b00;
            tmr_q       <= '0;
            score_q     <= '0;
            miss_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            lane_q      <= lane_d;
            pend_v_q    <= pend_v_d;
            pend_code_q <= pend_code_d;
            ind_q       <= ind_d;
            tmr_q       <= tmr_d;
            score_q     <= score_d;
            miss_q      <= miss_d;
        end
    end

    assign spawn_ready = !pend_v_q;
    assign arrow_array = lane_q;
    assign indicator   = ind_q;
    assign score       = score_q;
    assign miss_count  = miss_q;

endmodule

// File: doc/arrow_lane_sequencer.md
# arrow_lane_sequencer

Per-player scrolling note lane that produces the 78-bit arrow array and 2-bit judgement indicator consumed by the pixel colour-index stage. It scrolls a 26-slot queue of 3-bit arrow codes one slot every step, accepts new arrows from the chart source at the top slot, and judges button presses against the target block. The target block is the slots drawn over the static arrow blocks. One instance is used per player; its outputs feed `p1_arrow_array`/`p1_indicator` or `p2_arrow_array`/`p2_indicator`.

## Interface
Parameters:
- `TICK_DIV`, 1666666: clock cycles per scroll step (30 steps/s at 50 MHz); minimum 2.
- `HOLD_STEPS`, 8: steps an indicator value is held before returning to 00.
- `TARGET_SLOT`, 23: slot exactly aligned with the arrow block (rows 368–431).

Ports:
- `clock`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: 1 = RUN; 0 = PAUSE, which freezes the lane.
- `spawn_valid`, in, 1: chart source offers an arrow.
- `spawn_code`, in, 3: arrow code. 001 up, 010 left, 011 down, 100 right, 110 shake; any other value is stored as 000.
- `spawn_ready`, out, 1: the pending register is empty.
- `press_valid`, in, 1: one-cycle pulse for a debounced button press.
- `press_code`, in, 3: pressed lane, using the same encoding as `spawn_code`.
- `step`, out, 1: one-cycle pulse on each scroll step.
- `arrow_array`, out, 78: slot i occupies bits [3i+2:3i]; slot 0 is the top of the screen.
- `indicator`, out, 2: 11 excellent, 10 good, 01 bad, 00 none.
- `score`, out, 16: saturating score.
- `miss_count`, out, 8: saturating count of misses.

## Operation
- States:
  - PAUSE (`enable`=0): step counter, slots, indicator timer and spawn register hold; presses are ignored.
  - RUN (`enable`=1): normal operation.
  - Transitions follow `enable` every cycle. There are no other states.
- Spawn handshake:
  - `spawn_ready` = !pending.
  - `spawn_valid & spawn_ready` latches `spawn_code` into pending. This is allowed in PAUSE too.
  - On a step, pending moves into slot 0 and pending clears. With no pending arrow, slot 0 loads 000.
  - A spawn accepted in the same cycle as a step enters at the next step, not the current one.
- Scroll on step: slot[i+1] ← slot[i] for i = 0..24. The old slot 25 is discarded.
  - If old slot 25 ≠ 000, it is a miss: `miss_count`+1 and indicator ← 01.
- Judge on `press_valid` in RUN:
  - Search slots T, T−1, T+1 (T = `TARGET_SLOT`) in that priority for code == `press_code`.
  - Match at T: indicator ← 11, `score` += 2, the matched arrow is cleared to 000.
  - Match at T±1: indicator ← 10, `score` += 1, the matched arrow is cleared.
  - No match, or `press_code` = 000: indicator ← 01, no slot is changed.
- Simultaneous press and step:
  - Judging uses the pre-shift contents.
  - The clear is applied to the post-shift position. A match at slot k zeroes slot k+1 after the shift.
  - If a miss occurs in the same cycle, the press result sets the indicator and `miss_count` still increments.
- Indicator timer:
  - Every indicator write reloads the timer to `HOLD_STEPS`.
  - The timer decrements on each step. When it reaches 0, indicator ← 00.
- `score` saturates at 16'hFFFF. `miss_count` saturates at 8'hFF.

## Timing
- Reset values: `arrow_array`=0, `indicator`=00, `score`=0, `miss_count`=0, `step`=0, `spawn_ready`=1. The step counter is 0, pending is empty, the timer is 0.
- The step counter counts 0..`TICK_DIV`−1 in RUN. `step` is high in the cycle the counter is at `TICK_DIV`−1, and the shift and counter wrap take effect on that edge.
  - The first step after reset occurs `TICK_DIV` cycles after `enable` rises.
- All outputs are registered. A shift, clear or judgement is visible on outputs 1 cycle after the triggering edge.
- An arrow spawned before step n reaches slot 23 after step n+23 and leaves the lane (miss) at step n+26.
- `reset` asserted mid-operation clears everything on the next edge and overrides `enable`, spawn and press in that cycle.

## Test plan
All scenarios use `TICK_DIV`=4 and `HOLD_STEPS`=2.
- Reset, then `enable`=1 with no spawns → `step` every 4 cycles, `arrow_array` stays 0, `spawn_ready`=1.
- Spawn 010 once → `spawn_ready` drops for 1 step. Bits [2:0]=010 after the first step, and bits [71:69]=010 after the 24th step.
- Press 010 while the arrow sits in slot 23 → indicator=11, `score`=2, slot 23 = 000. Indicator returns to 00 after 2 steps.
- Press 010 with the arrow in slot 22 → indicator=10, `score`=1. Press 001 with no arrow in the window → indicator=01, `score` unchanged.
- Spawn 100 and never press → when the arrow leaves slot 25, `miss_count`=1 and indicator=01. Press 100 on the exact step edge with the arrow in slot 24 → indicator=10, and post-shift slot 25 = 000 with no miss.
- `enable`=0 for 10 cycles mid-scroll, then assert `reset` mid-run → no `step` and outputs frozen while paused; all outputs return to their reset values 1 cycle after `reset`.
